// File: rtl/prog_clk_div_pkg.sv
// Shared definitions for the programmable clock divider: FSM states,
// minimum ratio and the ratio helper functions.
package prog_clk_div_pkg;

    localparam int unsigned DIV_MIN = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } div_state_e;

    // Ratios 0 and 1 are meaningless for a divider; force them to the minimum.
    function automatic int unsigned clamp_div(input int unsigned x);
        return (x < DIV_MIN) ? DIV_MIN : x;
    endfunction

    // High-phase length: ceil(n/2), so odd ratios carry the extra cycle high.
    function automatic int unsigned high_len(input int unsigned n);
        return n - (n >> 1);
    endfunction

endpackage

// File: rtl/prog_clk_div_if.sv
// Control/status bundle of the programmable clock divider.
// Handshake: load_i is a single-cycle strobe with no back-pressure; div_i is
// valid only in a cycle where load_i is high. tick_o and upd_o are one-cycle
// strobes that the consumer must sample in the cycle they are high.
interface prog_clk_div_if #(
    parameter int WIDTH = 8
);
    import prog_clk_div_pkg::*;

    logic             en_i;
    logic             load_i;
    logic [WIDTH-1:0] div_i;
    logic             clk_o;
    logic             tick_o;
    logic             upd_o;
    logic             run_o;
    div_state_e       dbg_state;

    modport master (
        output en_i, load_i, div_i,
        input  clk_o, tick_o, upd_o, run_o, dbg_state
    );

    modport slave (
        input  en_i, load_i, div_i,
        output clk_o, tick_o, upd_o, run_o, dbg_state
    );

endinterface

// File: rtl/prog_clk_div.sv
// Runtime-programmable integer clock divider with near-50% duty, a
// clock-enable tick and ratio changes deferred to period boundaries.
module prog_clk_div
    import prog_clk_div_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int DIV_RST = 2
) (
    input  logic                 clk_i,
    input  logic                 rst,
    prog_clk_div_if.slave        bus
);

    div_state_e       state_q, state_d;
    logic [WIDTH-1:0] cnt_q,   cnt_d;
    logic [WIDTH-1:0] n_q,     n_d;
    logic [WIDTH-1:0] pend_q,  pend_d;
    logic             pend_v_q, pend_v_d;
    logic             clk_q,   clk_d;
    logic             tick_q,  tick_d;
    logic             upd_q,   upd_d;

    logic [WIDTH-1:0] div_cl;
    logic             wrap;

    assign div_cl = WIDTH'(clamp_div(32'(bus.div_i)));
    assign wrap   = (cnt_q == (n_q - WIDTH'(1)));

    // State and output registers; async reset drops every output at once
    // and discards any staged ratio.
    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            n_q      <= WIDTH'(DIV_RST);
            pend_q   <= '0;
            pend_v_q <= 1'b0;
            clk_q    <= 1'b0;
            tick_q   <= 1'b0;
            upd_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            n_q      <= n_d;
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
            clk_q    <= clk_d;
            tick_q   <= tick_d;
            upd_q    <= upd_d;
        end
    end

    // Next-state logic: count within the period, pick the next ratio at the
    // wrap edge, and only stop once the current period has completed.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        n_d      = n_q;
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        clk_d    = 1'b0;
        tick_d   = 1'b0;
        upd_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (bus.load_i) begin
                    n_d      = div_cl;
                    upd_d    = 1'b1;
                    pend_v_d = 1'b0;
                end
                if (bus.en_i) begin
                    state_d = ST_RUN;
                    clk_d   = 1'b1;
                    tick_d  = 1'b1;
                end
            end

            ST_RUN: begin
                if (wrap) begin
                    cnt_d    = '0;
                    pend_v_d = 1'b0;
                    if (bus.load_i) begin
                        n_d   = div_cl;
                        upd_d = 1'b1;
                    end else if (pend_v_q) begin
                        n_d   = pend_q;
                        upd_d = 1'b1;
                    end
                    if (bus.en_i) begin
                        clk_d  = (32'(cnt_d) < high_len(32'(n_d)));
                        tick_d = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d  = cnt_q + WIDTH'(1);
                    clk_d  = (32'(cnt_d) < high_len(32'(n_q)));
                    tick_d = (cnt_d == '0);
                    if (bus.load_i) begin
                        pend_d   = div_cl;
                        pend_v_d = 1'b1;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.clk_o     = clk_q;
    assign bus.tick_o    = tick_q;
    assign bus.upd_o     = upd_q;
    assign bus.run_o     = (state_q == ST_RUN);
    assign bus.dbg_state = state_q;

endmodule

// File: doc/prog_clk_div.md
# prog_clk_div

Runtime-programmable integer clock divider: the parametrised successor to the fixed and power-of-two dividers in the common modules. It divides clk_i by any ratio N from 2 to 2^WIDTH-1, with near-50 % duty. Ratio changes are applied only at period boundaries, so the output never produces a short pulse. It also provides a single-cycle tick synchronous to clk_i, for use as a clock enable in place of clk_o.

## Interface
- WIDTH, 8: ratio/counter width; maximum ratio 2^WIDTH-1.
- DIV_RST, 2: ratio in effect after reset; must be ≥ 2.
- clk_i  in  1  input clock.
- rst  in  1  reset; asynchronous, active-high.
- en_i  in  1  run request; level.
- div_i  in  WIDTH  requested ratio N; values 0 and 1 are clamped to 2.
- load_i  in  1  single-cycle strobe; samples div_i.
- clk_o  out  1  divided clock, registered.
- tick_o  out  1  one clk_i cycle high, coincident with each rising clk_o.
- upd_o  out  1  one-cycle pulse when a new ratio takes effect.
- run_o  out  1  divider running.

## Operation
- **Registers**
  - cnt: WIDTH bits.
  - n: active ratio.
  - pend, pend_v: staged ratio and its valid flag.
  - run.
  - H = N − floor(N/2), i.e. the high-phase length (ceil(N/2)).
- **Reset values:** cnt=0, n=DIV_RST, pend_v=0, run=0, clk_o=0, tick_o=0, upd_o=0, run_o=0.
- **IDLE (run=0)**
  - clk_o is held at 0 and cnt at 0.
  - load_i: n <= clamp(div_i), upd_o pulses on the next cycle, and pend_v is cleared.
  - en_i=1: run<=1, cnt<=0, clk_o<=1, tick_o<=1.
  - If load_i and en_i arrive together, the new ratio applies to the first period.
- **RUN: every edge**
  - cnt <= (cnt==n−1) ? 0 : cnt+1.
  - clk_o <= (next cnt < H).
  - tick_o <= (next cnt == 0).
- **RUN: load_i with no wrap** sets pend<=clamp(div_i) and pend_v<=1. If a ratio is already pending, the later load overwrites it (last wins).
- **RUN: wrap edge (cnt==n−1)**
  - Ratio for the next period is: load_i ? clamp(div_i) : pend_v ? pend : n.
  - upd_o pulses if the ratio came from load_i or pend; pend_v is cleared.
  - H is recomputed from the new ratio.
- **Stop**
  - en_i=0 does not truncate the current period. The divider keeps counting, and at the wrap edge with en_i=0 it sets run<=0, clk_o<=0, tick_o<=0, cnt<=0.
  - en_i high again at or before the wrap edge means the stop never happens.
- A pending ratio at stop is applied at the wrap edge, as for a normal wrap.
- run_o = run.

## Timing
- **Start latency:** clk_o and tick_o rise one clk_i cycle after the edge at which en_i is sampled high in IDLE.
- **Period:** exactly n clk_i cycles. clk_o is high for H cycles and low for n−H.
  - Even N gives 50 % duty.
  - Odd N gives one extra high cycle.
- **Ratio change:** a load at any cycle k of a period takes effect at that period's wrap, never mid-period. upd_o is high in the first cycle of the new period, together with tick_o.
- **Outputs:** all are registered with no combinational path from inputs; clk_o is glitch-free.
- **Async reset mid-period:** all outputs go to 0 immediately; the pending ratio is discarded and n returns to DIV_RST.

## Structure
- **Shared common-modules package**
  - DIV_MIN = 2.
  - Function clamp_div(x): returns x < 2 ? 2 : x.
  - Function high_len(n): returns n − (n >> 1).
- **Module:** single module prog_clk_div; no sub-module. Multi-output designs instantiate it per channel.

## Test plan
- **Reset, ratio 4:** WIDTH=8, DIV_RST=4, en_i=1 after reset.
  - clk_o pattern 1,1,0,0 repeating.
  - tick_o every 4th cycle.
  - First clk_o high one cycle after en_i is sampled.
- **Odd ratio:** load div_i=5 in IDLE.
  - upd_o pulses once.
  - clk_o is high 3 cycles, low 2; period 5.
- **Mid-period change:** running at N=6, load 3 at cnt=2, then load 7 at cnt=4.
  - Current period completes at 6 cycles.
  - Next period is 7 (last wins), with upd_o on its first cycle together with tick_o.
- **Clamp:** load div_i=0, then div_i=1.
  - Both give period 2, clk_o toggling every cycle.
- **Stop and restart:** drop en_i at cnt=1 of an N=8 period.
  - Period completes at 8 cycles; clk_o then stays 0 and run_o falls.
  - Re-raising en_i restarts with clk_o high after 1 cycle.
- **Async reset:** assert rst mid high-phase at N=10 with a ratio pending.
  - clk_o, tick_o, upd_o and run_o drop immediately.
  - After release and en_i=1, the period is DIV_RST.
